pipeline_mem_arbiter: RTL and testbench

//  Shares one variable-latency memory bus between the pipeline's instruction-fetch port and data port (unified memory).

---
 rtl/pipeline_mem_pkg.sv | 20 ++
 rtl/arbiter_starve_counter.sv | 28 ++
 rtl/pipeline_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the pipeline memory arbiter.
package pipeline_mem_pkg;

    // Arbiter FSM states: idle/arbitrate, fetch on bus, data op on bus, response pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    // Fetches always move a full word
    localparam logic [2:0] FETCH_FORMAT = 3'b010;

    // True while a transaction owns the memory bus
    function automatic logic is_busy(arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/arbiter_starve_counter.sv
// Counts consecutive data grants that overtook a pending fetch; saturates at STARVE_LIMIT.
module arbiter_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic saturated
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] count_reg;

    assign saturated = (count_reg == CNT_W'(STARVE_LIMIT));

    // Clear has priority; increment stops once the limit is reached
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !saturated) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Shares one variable-latency memory bus between instruction fetch and data access.
// Data wins arbitration unless fetch has been overtaken STARVE_LIMIT times in a row.
module pipeline_mem_arbiter
    import pipeline_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_available,
    input  logic        data_read_enable,
    input  logic        data_write_enable,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write_data,
    input  logic [2:0]  data_format,
    output logic [31:0] data_read_data,
    output logic        data_available,
    output logic        bus_req,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [2:0]  bus_format,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    arb_state_t state_reg;
    arb_state_t state_next;
    logic       drop_reg;
    logic       resp_is_data_reg;

    logic in_idle;
    logic data_pending;
    logic grant_data;
    logic grant_inst;
    logic starve_inc;
    logic starve_clr;
    logic starve_saturated;

    assign in_idle      = (state_reg == IDLE);
    assign data_pending = data_read_enable | data_write_enable;
    // Data is the older instruction, so it wins unless fetch is starved
    assign grant_data   = in_idle & data_pending & ~(inst_req & starve_saturated);
    // A redirect this cycle makes the presented fetch address stale
    assign grant_inst   = in_idle & ~grant_data & inst_req & ~flush;
    assign starve_inc   = grant_data & inst_req;
    assign starve_clr   = grant_inst | (in_idle & ~inst_req);

    arbiter_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock     (clock),
        .reset     (reset),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .saturated (starve_saturated)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_data) begin
                    state_next = BUSY_D;
                end else if (grant_inst) begin
                    state_next = BUSY_I;
                end
            end
            BUSY_D: begin
                if (bus_ready) begin
                    state_next = RESP;
                end
            end
            BUSY_I: begin
                // A fetch redirected while in flight completes silently
                if (bus_ready) begin
                    state_next = (drop_reg | flush) ? IDLE : RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        bus_req        = is_busy(state_reg);
        inst_available = 1'b0;
        data_available = 1'b0;
        if (state_reg == RESP) begin
            data_available = resp_is_data_reg;
            inst_available = ~resp_is_data_reg;
        end
    end

    // Bus register set: loaded on grant, held stable for the whole transaction
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_write        <= 1'b0;
            bus_addr         <= '0;
            bus_wdata        <= '0;
            bus_format       <= '0;
            resp_is_data_reg <= 1'b0;
        end else if (grant_data) begin
            // Read and write together is treated as a store
            bus_write        <= data_write_enable;
            bus_addr         <= data_addr;
            bus_wdata        <= data_write_data;
            bus_format       <= data_format;
            resp_is_data_reg <= 1'b1;
        end else if (grant_inst) begin
            bus_write        <= 1'b0;
            bus_addr         <= inst_addr;
            bus_wdata        <= '0;
            bus_format       <= FETCH_FORMAT;
            resp_is_data_reg <= 1'b0;
        end
    end

    // Drop flag remembers a flush seen during an in-flight fetch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_reg <= 1'b0;
        end else if ((state_reg == BUSY_I) && !bus_ready) begin
            drop_reg <= drop_reg | flush;
        end else begin
            drop_reg <= 1'b0;
        end
    end

    // Response registers: hold the last delivered fetch word and load result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_data      <= '0;
            data_read_data <= '0;
        end else if (bus_ready) begin
            if ((state_reg == BUSY_I) && !drop_reg && !flush) begin
                inst_data <= bus_rdata;
            end
            if ((state_reg == BUSY_D) && !bus_write) begin
                data_read_data <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared every cycle against a transaction-timeline reference model.
module tb_pipeline_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_data;
    logic        inst_available;
    logic        data_read_enable = 1'b0;
    logic        data_write_enable = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_write_data = '0;
    logic [2:0]  data_format = '0;
    logic [31:0] data_read_data;
    logic        data_available;
    logic        bus_req;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_format;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    pipeline_mem_arbiter #(
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock             (clk),
        .reset             (rst_n),
        .flush             (flush),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_data         (inst_data),
        .inst_available    (inst_available),
        .data_read_enable  (data_read_enable),
        .data_write_enable (data_write_enable),
        .data_addr         (data_addr),
        .data_write_data   (data_write_data),
        .data_format       (data_format),
        .data_read_data    (data_read_data),
        .data_available    (data_available),
        .bus_req           (bus_req),
        .bus_write         (bus_write),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_format        (bus_format),
        .bus_ready         (bus_ready),
        .bus_rdata         (bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Memory as seen by the bus (environment) and as the program expects it (reference)
    logic [31:0] env_mem [16];
    logic [31:0] ref_mem [16];

    // Reference model: one transaction at a time on a cycle timeline
    int          cyc = 0;
    int          next_arb = 0;
    bit          m_busy = 0;
    bit          m_kind_data = 0;
    bit          m_write = 0;
    bit          m_dropped = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [2:0]  m_fmt = '0;
    int          starve = 0;
    logic [31:0] exp_inst_data = '0;
    logic [31:0] exp_read_data = '0;
    int          wait_left = 0;
    int          wait_plan = 0;
    bit          noise = 0;
    bit          last_pi = 0;
    bit          last_pd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy        = 0;
        m_dropped     = 0;
        next_arb      = cyc;
        starve        = 0;
        exp_inst_data = '0;
        exp_read_data = '0;
        last_pi       = 0;
        last_pd       = 0;
    endtask

    // One clock cycle: memory response, model update, edge, full output comparison
    task automatic step();
        bit ready;
        bit win_d;
        bit win_i;
        bit pulse_i;
        bit pulse_d;
        pulse_i = 0;
        pulse_d = 0;
        if (m_busy) begin
            ready = (wait_left == 0);
            if (!ready) wait_left--;
            bus_rdata = env_mem[bus_addr[5:2]];
        end else begin
            ready = noise && ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
        end
        bus_ready = ready;
        if (m_busy && ready && bus_write) env_mem[bus_addr[5:2]] = bus_wdata;

        if (m_busy) begin
            if (!m_kind_data && flush) m_dropped = 1;
            if (ready) begin
                m_busy = 0;
                if (m_kind_data) begin
                    pulse_d = 1;
                    if (m_write) ref_mem[m_addr[5:2]] = m_wdata;
                    else exp_read_data = ref_mem[m_addr[5:2]];
                    next_arb = cyc + 2;
                end else if (m_dropped) begin
                    next_arb = cyc + 1;
                end else begin
                    pulse_i = 1;
                    exp_inst_data = ref_mem[m_addr[5:2]];
                    next_arb = cyc + 2;
                end
            end
        end else if (cyc == next_arb) begin
            win_d = (data_read_enable || data_write_enable) && !(inst_req && starve == LIMIT);
            win_i = !win_d && inst_req && !flush;
            if (!inst_req) starve = 0;
            else if (win_d) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else if (win_i) starve = 0;
            if (win_d || win_i) begin
                m_busy      = 1;
                m_dropped   = 0;
                m_kind_data = win_d;
                m_write     = win_d && data_write_enable;
                m_addr      = win_d ? data_addr : inst_addr;
                m_wdata     = data_write_data;
                m_fmt       = win_d ? data_format : 3'b010;
                wait_left   = (wait_plan >= 0) ? wait_plan : int'($urandom_range(0, 3));
            end else begin
                next_arb = cyc + 1;
            end
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("bus_req", 32'(bus_req), 32'(m_busy));
        if (m_busy) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_write", 32'(bus_write), 32'(m_write));
            chk("bus_format", 32'(bus_format), 32'(m_fmt));
            if (m_write) chk("bus_wdata", bus_wdata, m_wdata);
        end
        chk("inst_available", 32'(inst_available), 32'(pulse_i));
        chk("data_available", 32'(data_available), 32'(pulse_d));
        chk("inst_data", inst_data, exp_inst_data);
        chk("data_read_data", data_read_data, exp_read_data);
        last_pi = pulse_i;
        last_pd = pulse_d;
        // The pipeline withdraws a request once it has been answered
        if (pulse_i) inst_req = 0;
        if (pulse_d) begin
            data_read_enable  = 0;
            data_write_enable = 0;
        end
    endtask

    task automatic drain(input int max);
        bit done;
        done = 0;
        flush = 0;
        for (int k = 0; k < max; k++) begin
            if (!m_busy && !inst_req && !data_read_enable && !data_write_enable) begin
                done = 1;
                break;
            end
            step();
        end
        chk("drain_done", 32'(done), 32'd1);
        step();
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  grants;
        bit  fetch_seen;
        bit  prev_req;
        int  op;

        for (int i = 0; i < 16; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        env_mem[0] = 32'h0000_0013;
        ref_mem[0] = 32'h0000_0013;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_inst_available", 32'(inst_available), 32'd0);
        chk("rst_data_available", 32'(data_available), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_write", 32'(bus_write), 32'd0);
        chk("rst_bus_format", 32'(bus_format), 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_data_read_data", data_read_data, 32'd0);
        rst_n = 1;
        model_reset();

        // T1: fetch 0x100, memory ready on first busy cycle
        wait_plan = 0;
        inst_req  = 1;
        inst_addr = 32'h0000_0100;
        step();
        step();
        chk("t1_inst_available_cycle2", 32'(inst_available), 32'd1);
        chk("t1_inst_data", inst_data, 32'h0000_0013);
        drain(10);

        // T2: fetch and load together; load goes first
        wait_plan         = 1;
        inst_req          = 1;
        inst_addr         = 32'h0000_0104;
        data_read_enable  = 1;
        data_addr         = 32'h0000_2000;
        step();
        chk("t2_first_addr", bus_addr, 32'h0000_2000);
        drain(20);

        // T3: load held continuously while fetch waits
        wait_plan        = 0;
        inst_req         = 1;
        inst_addr        = 32'h0000_0108;
        data_read_enable = 1;
        data_addr        = 32'h0000_0004;
        grants           = 0;
        fetch_seen       = 0;
        prev_req         = bus_req;
        for (int k = 0; k < 60 && !fetch_seen; k++) begin
            step();
            if (bus_req && !prev_req) begin
                if (bus_addr == inst_addr) fetch_seen = 1;
                else grants++;
            end
            prev_req = bus_req;
            if (!fetch_seen && !data_read_enable) data_read_enable = 1;
        end
        chk("t3_fetch_granted", 32'(fetch_seen), 32'd1);
        chk("t3_data_grants_before_fetch", 32'(grants), 32'(LIMIT));
        data_read_enable = 0;
        drain(20);

        // T4: flush in second busy cycle of a fetch with 3 wait cycles
        wait_plan = 3;
        inst_req  = 1;
        inst_addr = 32'h0000_010C;
        step();
        step();
        flush = 1;
        step();
        flush    = 0;
        inst_req = 0;
        for (int k = 0; k < 6; k++) step();
        chk("t4_idle_bus_req", 32'(bus_req), 32'd0);
        chk("t4_inst_data_kept", inst_data, exp_inst_data);

        // T5: byte store of 0xDEADBEEF to 0x40, then read it back
        wait_plan         = 2;
        data_write_enable = 1;
        data_addr         = 32'h0000_0040;
        data_write_data   = 32'hDEAD_BEEF;
        data_format       = 3'b000;
        step();
        chk("t5_bus_write", 32'(bus_write), 32'd1);
        drain(20);
        data_read_enable = 1;
        data_format      = 3'b010;
        drain(20);
        chk("t5_readback", data_read_data, 32'hDEAD_BEEF);

        // T6: asynchronous reset during a data transaction
        wait_plan        = 5;
        data_read_enable = 1;
        data_addr        = 32'h0000_0010;
        inst_req         = 1;
        inst_addr        = 32'h0000_0120;
        step();
        step();
        #1;
        rst_n = 0;
        #1;
        chk("t6_bus_req_async", 32'(bus_req), 32'd0);
        chk("t6_data_available", 32'(data_available), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        wait_plan = 0;
        drain(40);

        // Randomized traffic
        wait_plan = -1;
        noise     = 1;
        for (int k = 0; k < 1500; k++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req  = 1;
                inst_addr = 32'h0000_0100 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!data_read_enable && !data_write_enable && $urandom_range(0, 3) == 0) begin
                op                = int'($urandom_range(0, 3));
                data_read_enable  = (op != 2);
                data_write_enable = (op >= 2);
                data_addr         = 32'h0000_2000 | (32'($urandom_range(0, 15)) << 2);
                data_write_data   = $urandom;
                data_format       = 3'($urandom_range(0, 7));
            end
            flush = ($urandom_range(0, 7) == 0);
            if (flush && inst_req) inst_addr = 32'h0000_0100 | (32'($urandom_range(0, 15)) << 2);
            step();
        end
        noise = 0;
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
